// File: rtl/red_pitaya_limit_slew_if.sv
// Register bus between software and the limiter block.
// Bus master drives address, write data and the one-cycle write/read strobes.
// The limiter returns read data, an error flag and an acknowledge.
interface red_pitaya_limit_slew_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface

// File: rtl/red_pitaya_limit_slew.sv
// Multi-channel DAC output limiter: clamps each signed channel to a programmable
// [MIN,MAX] window, then optionally slew-rate limits it, with live/sticky railed flags.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   dat_i         CHN packed signed DW-bit input samples
//   dat_o         CHN packed limited samples (1-cycle latency)
//   railed_o      per channel {upper,lower} live railed flags
//   slewing_o     per channel slew-limiter-active flag
//   sys           register bus (slave side)
module red_pitaya_limit_slew #(
   parameter int unsigned CHN = 2,
   parameter int unsigned DW  = 14
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [CHN*DW-1:0]       dat_i,
   output logic [CHN*DW-1:0]       dat_o,
   output logic [CHN*2-1:0]        railed_o,
   output logic [CHN-1:0]          slewing_o,
   red_pitaya_limit_slew_if.slave  sys
);
   localparam int unsigned CW = (CHN > 1) ? $clog2(CHN) : 1;

   logic signed [DW-1:0] r_min  [CHN];
   logic signed [DW-1:0] r_max  [CHN];
   logic        [DW-1:0] r_step [CHN];
   logic                 r_ack;
   logic                 r_err;
   logic        [31:0]   r_rdata;

   logic [27:0]      w_ch;
   logic [3:0]       w_off;
   logic [1:0]       w_reg;
   logic [CW-1:0]    w_sel;
   logic             w_hit;
   logic [31:0]      w_rd;
   logic [CHN*2-1:0] w_sticky_rail;
   logic [CHN-1:0]   w_sticky_slew;
   logic [CHN-1:0]   w_invalid;
   logic [CHN*2-1:0] w_clr_rail;
   logic [CHN-1:0]   w_clr_slew;
   logic             w_unused;

   // Address decode: channel in [31:4], register offset in [3:0]
   assign w_ch     = sys.sys_addr[31:4];
   assign w_off    = sys.sys_addr[3:0];
   assign w_reg    = sys.sys_addr[3:2];
   assign w_sel    = sys.sys_addr[4 +: CW];
   assign w_hit    = (w_ch < 28'(CHN)) && (w_off <= 4'hC);
   assign w_unused = ^sys.sys_wdata[31:DW];

   // Read mux, sampled from the pre-write register state
   always_comb begin
      w_rd = '0;
      if (w_hit) begin
         case (w_reg)
            2'd0:    w_rd = 32'($signed(r_min[w_sel]));
            2'd1:    w_rd = 32'($signed(r_max[w_sel]));
            2'd2:    w_rd = 32'(r_step[w_sel]);
            default: w_rd = 32'({w_sticky_slew[w_sel], w_invalid[w_sel],
                                 w_sticky_rail[2*w_sel +: 2], railed_o[2*w_sel +: 2]});
         endcase
      end
   end

   // Write-1-to-clear strobes for the sticky status bits
   always_comb begin
      w_clr_rail = '0;
      w_clr_slew = '0;
      if (sys.sys_wen && w_hit && (w_reg == 2'd3)) begin
         w_clr_rail[2*w_sel +: 2] = sys.sys_wdata[3:2];
         w_clr_slew[w_sel]        = sys.sys_wdata[5];
      end
   end

   // Bus response and configuration registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < CHN; i++) begin
            r_min[i]  <= {1'b1, {(DW-1){1'b0}}};
            r_max[i]  <= {1'b0, {(DW-1){1'b1}}};
            r_step[i] <= '0;
         end
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= sys.sys_wen | sys.sys_ren;
         r_err   <= (sys.sys_wen | sys.sys_ren) & ~w_hit;
         r_rdata <= (sys.sys_ren && w_hit) ? w_rd : '0;
         if (sys.sys_wen && w_hit) begin
            case (w_reg)
               2'd0:    r_min[w_sel]  <= $signed(sys.sys_wdata[DW-1:0]);
               2'd1:    r_max[w_sel]  <= $signed(sys.sys_wdata[DW-1:0]);
               2'd2:    r_step[w_sel] <= sys.sys_wdata[DW-1:0];
               default: ;
            endcase
         end
      end
   end

   assign sys.sys_ack   = r_ack;
   assign sys.sys_err   = r_err;
   assign sys.sys_rdata = r_rdata;

   for (genvar c = 0; c < CHN; c++) begin : g_ch
      logic signed [DW-1:0] r_dat;
      logic        [1:0]    r_rail;
      logic        [1:0]    r_sticky_rail;
      logic                 r_slew;
      logic                 r_sticky_slew;

      logic signed [DW-1:0] w_in;
      logic signed [DW-1:0] w_tgt;
      logic signed [DW-1:0] w_nxt_dat;
      logic signed [DW:0]   w_d;
      logic signed [DW:0]   w_step;
      logic signed [DW:0]   w_out_ext;
      logic        [1:0]    w_nxt_rail;
      logic                 w_nxt_slew;
      logic                 w_inv;

      assign w_in      = $signed(dat_i[c*DW +: DW]);
      assign w_inv     = r_min[c] > r_max[c];
      assign w_step    = $signed({1'b0, r_step[c]});
      assign w_out_ext = (DW+1)'(r_dat);

      // Clamp to window, then step at most STEP towards the target; the
      // DW+1-bit result always lies between r_dat and target so it fits DW bits
      always_comb begin
         w_nxt_dat  = '0;
         w_nxt_rail = 2'b11;
         w_nxt_slew = 1'b0;
         w_tgt      = w_in;
         w_d        = '0;
         if (!w_inv) begin
            w_nxt_rail = {w_in > r_max[c], w_in < r_min[c]};
            if (w_in > r_max[c])
               w_tgt = r_max[c];
            else if (w_in < r_min[c])
               w_tgt = r_min[c];
            w_d       = (DW+1)'(w_tgt) - w_out_ext;
            w_nxt_dat = w_tgt;
            if (r_step[c] != '0) begin
               if (w_d > w_step) begin
                  w_nxt_dat  = DW'(w_out_ext + w_step);
                  w_nxt_slew = 1'b1;
               end else if (w_d < -w_step) begin
                  w_nxt_dat  = DW'(w_out_ext - w_step);
                  w_nxt_slew = 1'b1;
               end
            end
         end
      end

      // Output and status registers; a new event beats a same-cycle clear
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_dat         <= '0;
            r_rail        <= '0;
            r_slew        <= 1'b0;
            r_sticky_rail <= '0;
            r_sticky_slew <= 1'b0;
         end else begin
            r_dat         <= w_nxt_dat;
            r_rail        <= w_nxt_rail;
            r_slew        <= w_nxt_slew;
            r_sticky_rail <= (r_sticky_rail & ~w_clr_rail[2*c +: 2]) | w_nxt_rail;
            r_sticky_slew <= (r_sticky_slew & ~w_clr_slew[c]) | w_nxt_slew;
         end
      end

      assign dat_o[c*DW +: DW]       = r_dat;
      assign railed_o[2*c +: 2]      = r_rail;
      assign slewing_o[c]            = r_slew;
      assign w_sticky_rail[2*c +: 2] = r_sticky_rail;
      assign w_sticky_slew[c]        = r_sticky_slew;
      assign w_invalid[c]            = w_inv;
   end
endmodule
